// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared 8-bit register bus.
// Define REG_ARB_TIMEOUT_EN to add the forced release of an abandoned bus lock.
module reg_bus_arbiter #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pRD_LATENCY   = 1,
    parameter int pLOCK_TIMEOUT = 1023
) (
    input  logic                     clk_usb,
    input  logic                     reset_i,

    input  logic                     m0_req,
    input  logic                     m0_lock,
    input  logic                     m0_write,
    input  logic [7:0]               m0_addr,
    input  logic [pBYTECNT_SIZE-1:0] m0_bytecnt,
    input  logic [7:0]               m0_wdata,
    output logic                     m0_ack,
    output logic [7:0]               m0_rdata,
    output logic                     m0_grant,

    input  logic                     m1_req,
    input  logic                     m1_lock,
    input  logic                     m1_write,
    input  logic [7:0]               m1_addr,
    input  logic [pBYTECNT_SIZE-1:0] m1_bytecnt,
    input  logic [7:0]               m1_wdata,
    output logic                     m1_ack,
    output logic [7:0]               m1_rdata,
    output logic                     m1_grant,

    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               reg_datao,
    input  logic [7:0]               reg_datai,
    output logic                     reg_addrvalid,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     lock_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RDWAIT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    logic       owner_q, owner_d;
    logic       gnt_q, gnt_d;
    logic       av_q, av_d;
    logic       last_q, last_d;
    logic       is_rd_q, is_rd_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic [1:0] ack_q, ack_d;
    logic [1:0] armed_q, armed_d;
    logic [2:0] rdcnt_q, rdcnt_d;
    logic       load;
    logic       cap;

    logic [7:0]               addr_q;
    logic [pBYTECNT_SIZE-1:0] bc_q;
    logic [7:0]               datao_q;
    logic [7:0]               rdata0_q;
    logic [7:0]               rdata1_q;

    logic [1:0] req_v;
    logic [1:0] elig;
    logic       own_lock;
    logic       own_write;
    logic       own_elig;

`ifdef REG_ARB_TIMEOUT_EN
    logic [9:0] tcnt_q, tcnt_d;
    logic       tmo_q, tmo_d;
    logic       own_req;
`else
    wire unused_lock_timeout = (pLOCK_TIMEOUT != 0);
`endif

    always_comb begin
        req_v     = {m1_req, m0_req};
        elig      = armed_q & req_v;
        own_lock  = owner_q ? m1_lock : m0_lock;
        own_write = owner_q ? m1_write : m0_write;
        own_elig  = owner_q ? elig[1] : elig[0];
`ifdef REG_ARB_TIMEOUT_EN
        own_req   = owner_q ? m1_req : m0_req;
`endif
    end

    // req low re-arms even in the ack cycle, so a dropped req is never lost
    always_comb begin
        armed_d = armed_q;
        for (int n = 0; n < 2; n++) begin
            if (state_q == S_DONE && owner_q == 1'(n))
                armed_d[n] = 1'b0;
            if (!req_v[n])
                armed_d[n] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        av_d    = av_q;
        last_d  = last_q;
        is_rd_d = is_rd_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ack_d   = 2'b00;
        rdcnt_d = rdcnt_q;
        load    = 1'b0;
        cap     = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (elig != 2'b00) begin
                    owner_d = (elig == 2'b11) ? ~last_q : elig[1];
                    gnt_d   = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                load    = 1'b1;
                av_d    = 1'b1;
                is_rd_d = ~own_write;
                wr_d    = own_write;
                rd_d    = ~own_write;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                rdcnt_d = 3'd0;
                if (is_rd_q) begin
                    state_d = S_RDWAIT;
                end else begin
                    ack_d[owner_q] = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_RDWAIT: begin
                if (rdcnt_q == 3'(pRD_LATENCY - 1)) begin
                    cap            = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    rdcnt_d = rdcnt_q + 3'd1;
                end
            end
            S_DONE: begin
                last_d = owner_q;
`ifdef REG_ARB_TIMEOUT_EN
                tcnt_d = 10'd0;
`endif
                if (own_lock) begin
                    state_d = S_HOLD;
                end else begin
                    gnt_d   = 1'b0;
                    av_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!own_lock) begin
                    gnt_d   = 1'b0;
                    av_d    = 1'b0;
                    state_d = S_IDLE;
                end else if (own_elig) begin
`ifdef REG_ARB_TIMEOUT_EN
                    tcnt_d  = 10'd0;
`endif
                    state_d = S_SETUP;
                end
`ifdef REG_ARB_TIMEOUT_EN
                else if (!own_req) begin
                    tcnt_d = tcnt_q + 10'd1;
                    if (tcnt_d == 10'(pLOCK_TIMEOUT)) begin
                        tmo_d   = 1'b1;
                        gnt_d   = 1'b0;
                        av_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            gnt_q    <= 1'b0;
            av_q     <= 1'b0;
            last_q   <= 1'b1;
            is_rd_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack_q    <= 2'b00;
            armed_q  <= 2'b11;
            rdcnt_q  <= 3'd0;
            addr_q   <= 8'h00;
            bc_q     <= '0;
            datao_q  <= 8'h00;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            av_q    <= av_d;
            last_q  <= last_d;
            is_rd_q <= is_rd_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            armed_q <= armed_d;
            rdcnt_q <= rdcnt_d;
            if (load) begin
                addr_q  <= owner_q ? m1_addr : m0_addr;
                bc_q    <= owner_q ? m1_bytecnt : m0_bytecnt;
                datao_q <= owner_q ? m1_wdata : m0_wdata;
            end
            if (cap && !owner_q)
                rdata0_q <= reg_datai;
            if (cap && owner_q)
                rdata1_q <= reg_datai;
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            tcnt_q <= 10'd0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign lock_timeout = tmo_q;
`else
    assign lock_timeout = 1'b0;
`endif

    assign m0_ack        = ack_q[0];
    assign m1_ack        = ack_q[1];
    assign m0_grant      = gnt_q & ~owner_q;
    assign m1_grant      = gnt_q & owner_q;
    assign m0_rdata      = rdata0_q;
    assign m1_rdata      = rdata1_q;
    assign reg_address   = addr_q;
    assign reg_bytecnt   = bc_q;
    assign reg_datao     = datao_q;
    assign reg_addrvalid = av_q;
    assign reg_read      = rd_q;
    assign reg_write     = wr_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed-vector bench for reg_bus_arbiter (lock watchdog length 8).
// Build with REG_ARB_TIMEOUT_EN to exercise the forced lock release.
module tb_reg_bus_arbiter;

    logic       clk_usb = 1'b0;
    logic       reset_i = 1'b1;
    logic       m0_req, m0_lock, m0_write;
    logic [7:0] m0_addr, m0_wdata;
    logic [6:0] m0_bytecnt;
    logic       m0_ack, m0_grant;
    logic [7:0] m0_rdata;
    logic       m1_req, m1_lock, m1_write;
    logic [7:0] m1_addr, m1_wdata;
    logic [6:0] m1_bytecnt;
    logic       m1_ack, m1_grant;
    logic [7:0] m1_rdata;
    logic [7:0] reg_address, reg_datao, reg_datai;
    logic [6:0] reg_bytecnt;
    logic       reg_addrvalid, reg_read, reg_write, lock_timeout;

    logic       rd_dly = 1'b0;
    logic [7:0] slave_val = 8'h00;

    int nvec = 0;
    int nfail = 0;

    always #5 clk_usb = ~clk_usb;

    // slave returns its data the cycle after the read strobe
    always @(posedge clk_usb) rd_dly <= reg_read;
    assign reg_datai = rd_dly ? slave_val : 8'h00;

    reg_bus_arbiter #(
        .pBYTECNT_SIZE(7),
        .pRD_LATENCY(1),
        .pLOCK_TIMEOUT(8)
    ) dut (
        .clk_usb(clk_usb), .reset_i(reset_i),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_write(m0_write),
        .m0_addr(m0_addr), .m0_bytecnt(m0_bytecnt), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_grant(m0_grant),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_write(m1_write),
        .m1_addr(m1_addr), .m1_bytecnt(m1_bytecnt), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_grant(m1_grant),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_datao(reg_datao), .reg_datai(reg_datai),
        .reg_addrvalid(reg_addrvalid), .reg_read(reg_read),
        .reg_write(reg_write), .lock_timeout(lock_timeout)
    );

    task automatic tick;
        @(posedge clk_usb);
        #1;
    endtask

    task automatic idle_inputs;
        m0_req = 0; m0_lock = 0; m0_write = 0;
        m0_addr = 0; m0_bytecnt = 0; m0_wdata = 0;
        m1_req = 0; m1_lock = 0; m1_write = 0;
        m1_addr = 0; m1_bytecnt = 0; m1_wdata = 0;
    endtask

    task automatic do_reset;
        reset_i = 1;
        idle_inputs();
        tick();
        tick();
        reset_i = 0;
    endtask

    task automatic test_reset;
        reset_i = 1;
        idle_inputs();
        tick();
        tick();
        nvec++;
        if ({m0_grant, m1_grant, m0_ack, m1_ack, reg_read, reg_write,
             reg_addrvalid, lock_timeout} !== 8'h00) begin
            nfail++;
            $display("FAIL reset_strobes: got %b%b%b%b%b%b%b%b want 00000000",
                     m0_grant, m1_grant, m0_ack, m1_ack, reg_read, reg_write,
                     reg_addrvalid, lock_timeout);
        end
        nvec++;
        if ({reg_address, reg_bytecnt, reg_datao} !== 23'h0) begin
            nfail++;
            $display("FAIL reset_bus: got %h/%h/%h want 00/00/00",
                     reg_address, reg_bytecnt, reg_datao);
        end
        nvec++;
        if ({m0_rdata, m1_rdata} !== 16'h0000) begin
            nfail++;
            $display("FAIL reset_rdata: got %h/%h want 00/00", m0_rdata, m1_rdata);
        end
        reset_i = 0;
        tick();
        nvec++;
        if ({m0_grant, m1_grant} !== 2'b00) begin
            nfail++;
            $display("FAIL reset_idle_grant: got %b%b want 00", m0_grant, m1_grant);
        end
    endtask

    task automatic test_single_write;
        m0_addr = 8'h2A; m0_bytecnt = 7'd3; m0_wdata = 8'h5C;
        m0_write = 1; m0_lock = 0;
        m0_req = 1;
        tick();
        nvec++;
        if ({m0_grant, reg_write} !== 2'b10) begin
            nfail++;
            $display("FAIL wr_t1: got grant=%b write=%b want 1/0", m0_grant, reg_write);
        end
        tick();
        nvec++;
        if ({reg_write, reg_read, reg_addrvalid} !== 3'b101) begin
            nfail++;
            $display("FAIL wr_t2_strobe: got w=%b r=%b av=%b want 1/0/1",
                     reg_write, reg_read, reg_addrvalid);
        end
        nvec++;
        if ({reg_address, reg_bytecnt, reg_datao} !== {8'h2A, 7'd3, 8'h5C}) begin
            nfail++;
            $display("FAIL wr_t2_bus: got %h/%0d/%h want 2a/3/5c",
                     reg_address, reg_bytecnt, reg_datao);
        end
        tick();
        nvec++;
        if ({m0_ack, reg_write} !== 2'b10) begin
            nfail++;
            $display("FAIL wr_t3: got ack=%b write=%b want 1/0", m0_ack, reg_write);
        end
        m0_req = 0;
        tick();
        nvec++;
        if ({m0_ack, m0_grant, reg_addrvalid} !== 3'b000) begin
            nfail++;
            $display("FAIL wr_t4: got ack=%b grant=%b av=%b want 0/0/0",
                     m0_ack, m0_grant, reg_addrvalid);
        end
    endtask

    task automatic test_read;
        slave_val = 8'hA7;
        m1_addr = 8'h10; m1_bytecnt = 7'd0; m1_write = 0; m1_lock = 0;
        m1_req = 1;
        tick();
        tick();
        nvec++;
        if ({m1_grant, reg_read, reg_write} !== 3'b110) begin
            nfail++;
            $display("FAIL rd_t2: got grant=%b r=%b w=%b want 1/1/0",
                     m1_grant, reg_read, reg_write);
        end
        tick();
        nvec++;
        if ({reg_read, m1_ack} !== 2'b00) begin
            nfail++;
            $display("FAIL rd_t3: got r=%b ack=%b want 0/0", reg_read, m1_ack);
        end
        tick();
        nvec++;
        if (m1_ack !== 1'b1 || m1_rdata !== 8'hA7) begin
            nfail++;
            $display("FAIL rd_t4: got ack=%b rdata=%h want 1/a7", m1_ack, m1_rdata);
        end
        nvec++;
        if (m0_rdata !== 8'h00) begin
            nfail++;
            $display("FAIL rd_other: got m0_rdata=%h want 00", m0_rdata);
        end
        m1_req = 0;
        tick();
        nvec++;
        if (m1_ack !== 1'b0 || m1_rdata !== 8'hA7) begin
            nfail++;
            $display("FAIL rd_hold: got ack=%b rdata=%h want 0/a7", m1_ack, m1_rdata);
        end
    endtask

    task automatic test_round_robin;
        int order[$];
        int done0 = 0;
        int done1 = 0;
        int cyc = 0;
        int both = 0;
        int got;
        do_reset();
        m0_write = 1; m0_addr = 8'h01; m0_wdata = 8'h11;
        m1_write = 1; m1_addr = 8'h02; m1_wdata = 8'h22;
        m0_req = 1; m1_req = 1;
        while ((done0 < 3 || done1 < 3) && cyc < 100) begin
            tick();
            cyc++;
            if (reg_read && reg_write) both++;
            if (m0_ack) begin
                order.push_back(0); done0++; m0_req = 0;
            end else if (!m0_req && done0 < 3) m0_req = 1;
            if (m1_ack) begin
                order.push_back(1); done1++; m1_req = 0;
            end else if (!m1_req && done1 < 3) m1_req = 1;
        end
        nvec++;
        if (cyc >= 100) begin
            nfail++;
            $display("FAIL rr_timeout: got %0d/%0d acks want 3/3", done0, done1);
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < order.size()) ? order[i] : -1;
            nvec++;
            if (got !== i % 2) begin
                nfail++;
                $display("FAIL rr_order[%0d]: got m%0d want m%0d", i, got, i % 2);
            end
        end
        nvec++;
        if (both !== 0) begin
            nfail++;
            $display("FAIL rr_strobes: got %0d dual-strobe cycles want 0", both);
        end
        tick();
    endtask

    task automatic test_lock;
        int cnt = 0;
        int cyc = 0;
        int last_ack = 0;
        int m1_early = 0;
        int wait_n = 0;
        do_reset();
        m0_write = 1; m0_addr = 8'h30; m0_wdata = 8'hC3; m0_lock = 1;
        m1_write = 1; m1_addr = 8'h40; m1_wdata = 8'h4D;
        m0_req = 1; m1_req = 1;
        while (cnt < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (m1_grant) m1_early++;
            if (m0_ack) begin
                cnt++;
                if (cnt > 1) begin
                    nvec++;
                    if (cyc - last_ack !== 4) begin
                        nfail++;
                        $display("FAIL lock_interval%0d: got %0d want 4",
                                 cnt, cyc - last_ack);
                    end
                end
                last_ack = cyc;
                m0_req = 0;
            end else if (!m0_req) m0_req = 1;
        end
        nvec++;
        if (cyc >= 60) begin
            nfail++;
            $display("FAIL lock_timeout_wait: got %0d acks want 4", cnt);
        end
        tick();
        nvec++;
        if ({m0_grant, reg_addrvalid, m1_grant} !== 3'b110) begin
            nfail++;
            $display("FAIL lock_hold: got g0=%b av=%b g1=%b want 1/1/0",
                     m0_grant, reg_addrvalid, m1_grant);
        end
        m0_lock = 0;
        tick();
        nvec++;
        if ({m0_grant, m1_grant, reg_addrvalid} !== 3'b000) begin
            nfail++;
            $display("FAIL lock_idle: got g0=%b g1=%b av=%b want 0/0/0",
                     m0_grant, m1_grant, reg_addrvalid);
        end
        tick();
        nvec++;
        if (m1_grant !== 1'b1) begin
            nfail++;
            $display("FAIL lock_m1_grant: got %b want 1", m1_grant);
        end
        nvec++;
        if (m1_early !== 0) begin
            nfail++;
            $display("FAIL lock_m1_early: got %0d cycles want 0", m1_early);
        end
        while (!m1_ack && wait_n < 10) begin
            tick();
            wait_n++;
        end
        nvec++;
        if (m1_ack !== 1'b1) begin
            nfail++;
            $display("FAIL lock_m1_ack: got %b want 1", m1_ack);
        end
        m1_req = 0;
        tick();
    endtask

    task automatic test_lock_timeout;
        int wait_n = 0;
        do_reset();
        m0_write = 1; m0_addr = 8'h50; m0_lock = 1;
        m1_write = 1; m1_addr = 8'h60;
        m0_req = 1; m1_req = 1;
        while (!m0_ack && wait_n < 10) begin
            tick();
            wait_n++;
        end
        nvec++;
        if (m0_ack !== 1'b1) begin
            nfail++;
            $display("FAIL tmo_m0_ack: got %b want 1", m0_ack);
        end
        m0_req = 0;
`ifdef REG_ARB_TIMEOUT_EN
        repeat (8) tick();
        nvec++;
        if ({m0_grant, lock_timeout} !== 2'b10) begin
            nfail++;
            $display("FAIL tmo_before: got g0=%b tmo=%b want 1/0", m0_grant, lock_timeout);
        end
        tick();
        nvec++;
        if ({lock_timeout, m0_grant, m1_grant} !== 3'b100) begin
            nfail++;
            $display("FAIL tmo_pulse: got tmo=%b g0=%b g1=%b want 1/0/0",
                     lock_timeout, m0_grant, m1_grant);
        end
        tick();
        nvec++;
        if ({m1_grant, lock_timeout} !== 2'b10) begin
            nfail++;
            $display("FAIL tmo_m1_grant: got g1=%b tmo=%b want 1/0", m1_grant, lock_timeout);
        end
        m0_lock = 0;
`else
        begin
            int bad = 0;
            repeat (20) begin
                tick();
                if (m1_grant || lock_timeout || !m0_grant) bad++;
            end
            nvec++;
            if (bad !== 0) begin
                nfail++;
                $display("FAIL hold_no_tmo: got %0d bad cycles want 0", bad);
            end
            m0_lock = 0;
            tick();
            tick();
            nvec++;
            if (m1_grant !== 1'b1) begin
                nfail++;
                $display("FAIL hold_release: got g1=%b want 1", m1_grant);
            end
        end
`endif
        wait_n = 0;
        while (!m1_ack && wait_n < 10) begin
            tick();
            wait_n++;
        end
        nvec++;
        if (m1_ack !== 1'b1) begin
            nfail++;
            $display("FAIL tmo_m1_ack: got %b want 1", m1_ack);
        end
        m1_req = 0;
        tick();
    endtask

    task automatic test_reset_midread;
        do_reset();
        slave_val = 8'h3C;
        m0_write = 0; m0_addr = 8'h44;
        m0_req = 1;
        tick();
        tick();
        nvec++;
        if (reg_read !== 1'b1) begin
            nfail++;
            $display("FAIL rst_rd_strobe: got %b want 1", reg_read);
        end
        tick();
        nvec++;
        if ({m0_grant, reg_read, m0_ack} !== 3'b100) begin
            nfail++;
            $display("FAIL rst_rdwait: got g0=%b r=%b ack=%b want 1/0/0",
                     m0_grant, reg_read, m0_ack);
        end
        reset_i = 1;
        m0_req = 0;
        tick();
        nvec++;
        if ({m0_ack, m0_grant, m1_grant, reg_addrvalid, reg_read} !== 5'b00000) begin
            nfail++;
            $display("FAIL rst_outputs: got ack=%b g0=%b g1=%b av=%b r=%b want 0s",
                     m0_ack, m0_grant, m1_grant, reg_addrvalid, reg_read);
        end
        nvec++;
        if ({m0_rdata, m1_rdata, reg_address} !== 24'h000000) begin
            nfail++;
            $display("FAIL rst_data: got %h/%h/%h want 00/00/00",
                     m0_rdata, m1_rdata, reg_address);
        end
        reset_i = 0;
        m0_req = 1;
        repeat (4) tick();
        nvec++;
        if (m0_ack !== 1'b1 || m0_rdata !== 8'h3C) begin
            nfail++;
            $display("FAIL rst_fresh_read: got ack=%b rdata=%h want 1/3c", m0_ack, m0_rdata);
        end
        m0_req = 0;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_lock();
        test_lock_timeout();
        test_reset_midread();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-requester arbiter and sequencer for the shared 8-bit register bus on `clk_usb`. It lets the USB host interface and a second internal master (the SAM SPI register bridge) reach the same register slaves, such as OpenADC, CW and glitch. It serialises transactions, generates the `reg_addrvalid`/`reg_read`/`reg_write` strobes and captures the ORed slave read data for the owning master. Round-robin fairness is combined with an optional bus lock for multi-byte register sequences.

## Interface
Parameters:
- `pBYTECNT_SIZE`, default 7: width of the byte-count fields.
- `pRD_LATENCY`, default 1: cycles from the `reg_read` strobe to sampling `reg_datai`, range 1–7.
- `pLOCK_TIMEOUT`, default 1023: idle cycles allowed in HOLD before the lock is forcibly released. Its counter is 10 bits.

Ports, with `n` = 0 or 1 for the per-master signals:
- `clk_usb`  in  1  single clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `mn_req`  in  1  level transaction request; hold until `mn_ack`.
- `mn_lock`  in  1  keep ownership after this transaction; sampled in the ack cycle and in HOLD.
- `mn_write`  in  1  1 = write, 0 = read.
- `mn_addr`  in  8  register address.
- `mn_bytecnt`  in  pBYTECNT_SIZE  byte index within the register.
- `mn_wdata`  in  8  write data.
- `mn_ack`  out  1  one-cycle completion pulse.
- `mn_rdata`  out  8  captured read data; held until that master's next read completes.
- `mn_grant`  out  1  master n owns the bus.
- `reg_address`  out  8  bus address.
- `reg_bytecnt`  out  pBYTECNT_SIZE  bus byte count.
- `reg_datao`  out  8  write data to slaves.
- `reg_datai`  in  8  ORed slave read data.
- `reg_addrvalid`  out  1  address phase valid.
- `reg_read`  out  1  one-cycle read strobe.
- `reg_write`  out  1  one-cycle write strobe.
- `lock_timeout`  out  1  one-cycle pulse when the lock is force-released. Tied to 0 without `REG_ARB_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RDWAIT, DONE, HOLD.
- Per-master `armed` flag:
  - Cleared in that master's ack cycle.
  - Set on any cycle its `req` is low.
  - Reset value is 1.
  - Only an armed master with `req`=1 is eligible. A level `req` that stays high after ack therefore cannot start a duplicate transaction.
- IDLE:
  - One eligible master: grant it and go to SETUP.
  - Both eligible: grant the master that is not `last_grant`. `last_grant` resets to 1, so master 0 wins the first tie.
- SETUP:
  - Register the granted master's `addr`, `bytecnt` and `wdata` onto the bus.
  - Set `reg_addrvalid`=1.
  - Go to ACCESS.
- ACCESS:
  - Pulse `reg_write` for a write, or `reg_read` for a read.
  - A write goes to DONE; a read goes to RDWAIT.
- RDWAIT:
  - Count `pRD_LATENCY` cycles.
  - On the last cycle, capture `reg_datai` into `mn_rdata` and go to DONE.
- DONE:
  - Pulse `mn_ack`, update `last_grant`, clear `armed`.
  - If `mn_lock`=1 go to HOLD; otherwise drop the grant and `reg_addrvalid` and go to IDLE.
- HOLD:
  - Grant and `reg_addrvalid` stay asserted; the other master is ignored.
  - Owner armed with `req`=1: go to SETUP.
  - Owner `lock`=0: go to IDLE, which takes priority over a simultaneous request.
- Bus address, byte count and data fields hold their last value when idle. There is no combinational path from `mn_*` to the bus.

## Timing
- Reset values:
  - All strobes, acks and grants are 0.
  - `reg_address`, `reg_bytecnt`, `reg_datao` and both `mn_rdata` are 0.
  - State is IDLE; the timeout counter is 0.
- Write from IDLE, with `req` seen at cycle T:
  - Grant and SETUP at T+1.
  - `reg_write` at T+2.
  - `ack` at T+3.
- Read, with `pRD_LATENCY`=L:
  - `reg_read` at T+2.
  - `reg_datai` sampled at T+2+L.
  - `ack` and `rdata` valid at T+3+L.
- Locked back-to-back write: owner re-armed with `req` at cycle H goes to SETUP at H+1, giving a 3-cycle issue interval plus one cycle for the `req` low gap.
- `reset_i` mid-transaction: the next cycle is IDLE with all outputs at reset values and no ack issued. An in-flight strobe is truncated to its already-issued cycle.
- Only one strobe is ever active per cycle. `reg_read` and `reg_write` are never both high.

## Configuration
- `REG_ARB_TIMEOUT_EN` defined:
  - In HOLD, a 10-bit counter increments each cycle without an owner request and resets on SETUP entry.
  - When it reaches `pLOCK_TIMEOUT`, pulse `lock_timeout` and go to IDLE, ignoring `lock`.
- Not defined:
  - HOLD persists until the owner drops `lock`.
  - The counter logic is absent and `lock_timeout`=0.

## Test plan
- Single write, m0 addr 0x2A, bytecnt 3, data 0x5C:
  - `reg_write` exactly one cycle, 2 cycles after `req`, with the bus showing 0x2A/3/0x5C.
  - `m0_ack` at +3 cycles.
- Read with L=1 and a slave driving 0xA7 one cycle after `reg_read`: `m1_rdata`=0xA7 and `m1_ack` 4 cycles after `req`. `m0_rdata` is unchanged.
- Both masters requesting from reset, held high for 3 transactions each with `req` low gaps: grants alternate m0, m1, m0, m1, m0, m1.
- m0 holds `lock` over 4 writes while m1 requests continuously:
  - m1 is not granted until m0 drops `lock`.
  - m1 is granted 1 cycle after entering IDLE.
- `REG_ARB_TIMEOUT_EN` with `pLOCK_TIMEOUT`=8:
  - m0 locks, then idles: `lock_timeout` pulses after 8 idle cycles and m1 is granted.
  - Without the macro, m1 never gets the bus.
- `reset_i` asserted in RDWAIT: next cycle has no ack, zero grants and zero `mn_rdata`. A fresh read then completes normally.
